// File: rtl/cpu_pkg.sv
// Shared encodings for the 4-bit-opcode CPU: opcodes, ALU controls,
// sequencer states and PC source selects.
package cpu_pkg;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_SUBC = 4'h5;
    localparam logic [3:0] OP_ADDC = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_ANDI = 4'h8;
    localparam logic [3:0] OP_ORI  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_LW   = 4'hB;
    localparam logic [3:0] OP_SW   = 4'hC;
    localparam logic [3:0] OP_BEQ  = 4'hD;
    localparam logic [3:0] OP_BNE  = 4'hE;
    localparam logic [3:0] OP_JMPB = 4'hF;

    localparam logic [2:0] ALUC_AND  = 3'b000;
    localparam logic [2:0] ALUC_SUB  = 3'b001;
    localparam logic [2:0] ALUC_SUBC = 3'b010;
    localparam logic [2:0] ALUC_SLT  = 3'b011;
    localparam logic [2:0] ALUC_ADDC = 3'b100;
    localparam logic [2:0] ALUC_ADD  = 3'b101;
    localparam logic [2:0] ALUC_OR   = 3'b110;
    localparam logic [2:0] ALUC_NOP  = 3'b111;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    localparam logic [1:0] PCSRC_INC = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    function automatic logic [2:0] aluc_of(input logic [3:0] op);
        logic [2:0] a;
        a = ALUC_NOP;
        case (op)
            OP_AND, OP_ANDI:         a = ALUC_AND;
            OP_SUB, OP_BEQ, OP_BNE:  a = ALUC_SUB;
            OP_SUBC:                 a = ALUC_SUBC;
            OP_SLT, OP_JMPB:         a = ALUC_SLT;
            OP_ADDC:                 a = ALUC_ADDC;
            OP_ADD, OP_ADDI,
            OP_LW, OP_SW:            a = ALUC_ADD;
            OP_OR, OP_ORI:           a = ALUC_OR;
            default:                 a = ALUC_NOP;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer (master) and the
// datapath (slave).
interface multicycle_ctrl_if #(
    parameter int OPW   = 4,
    parameter int ALUCW = 3
);
    logic             run;
    logic [OPW-1:0]   op;
    logic             ZERO;
    logic             mem_ready;
    logic             PCWRITE;
    logic [1:0]       PCSRC;
    logic             IRWRITE;
    logic             READMEM;
    logic             IORD;
    logic             WRITEMEM;
    logic [ALUCW-1:0] ALUC;
    logic             ALUSRCB;
    logic             WRITEREG;
    logic             MEMTOREG;
    logic             REGDES;
    logic             WRFLAG;
    logic             INSTR_DONE;
    logic [2:0]       STATE;

    modport master (
        input  run, op, ZERO, mem_ready,
        output PCWRITE, PCSRC, IRWRITE, READMEM, IORD, WRITEMEM,
        output ALUC, ALUSRCB, WRITEREG, MEMTOREG, REGDES, WRFLAG,
        output INSTR_DONE, STATE
    );

    modport slave (
        output run, op, ZERO, mem_ready,
        input  PCWRITE, PCSRC, IRWRITE, READMEM, IORD, WRITEMEM,
        input  ALUC, ALUSRCB, WRITEREG, MEMTOREG, REGDES, WRFLAG,
        input  INSTR_DONE, STATE
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the shared-ALU CPU datapath.
// Define MULTICYCLE_CTRL_MEM_WAIT_EN to stall FETCH/MEM on mem_ready.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int ALUCW = 3
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_ctrl_if.master bus
);

    logic [2:0]     state;
    logic [2:0]     state_n;
    logic [OPW-1:0] op_q;
    logic           ready;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign ready = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            op_q  <= '0;
        end else begin
            state <= state_n;
            if (state == ST_DECODE) op_q <= bus.op;
        end
    end

    logic is_lw, is_sw, is_imm, is_br, take;

    assign is_lw  = op_q == OP_LW;
    assign is_sw  = op_q == OP_SW;
    assign is_imm = op_q inside {OP_ANDI, OP_ORI, OP_ADDI, OP_LW, OP_SW};
    assign is_br  = op_q inside {OP_BEQ, OP_BNE, OP_JMPB};
    assign take   = (op_q == OP_BEQ  &&  bus.ZERO) ||
                    (op_q == OP_BNE  && !bus.ZERO) ||
                    (op_q == OP_JMPB &&  bus.ZERO);

    logic       pcw, irw, rdm, iord, wrm, asb;
    logic       wrg, m2r, rdes, wfl, done;
    logic [1:0] pcsrc;
    logic [2:0] aluc;

    always_comb begin
        state_n = state;
        pcw   = 1'b0;
        irw   = 1'b0;
        rdm   = 1'b0;
        iord  = 1'b0;
        wrm   = 1'b0;
        asb   = 1'b0;
        wrg   = 1'b0;
        m2r   = 1'b0;
        rdes  = 1'b0;
        wfl   = 1'b0;
        done  = 1'b0;
        pcsrc = PCSRC_INC;
        aluc  = ALUC_NOP;
        unique case (1'b1)
            (state == ST_FETCH): begin
                if (bus.run) begin
                    rdm = 1'b1;
                    if (ready) begin
                        pcw     = 1'b1;
                        irw     = 1'b1;
                        state_n = ST_DECODE;
                    end
                end
            end
            (state == ST_DECODE): begin
                if (bus.op == OP_JMP) begin
                    pcw     = 1'b1;
                    pcsrc   = PCSRC_JMP;
                    done    = 1'b1;
                    state_n = ST_FETCH;
                end else begin
                    state_n = ST_EXEC;
                end
            end
            (state == ST_EXEC): begin
                aluc = aluc_of(op_q);
                asb  = is_imm;
                if (is_br) begin
                    // ZERO is this cycle's ALU compare result
                    if (take) begin
                        pcw   = 1'b1;
                        pcsrc = PCSRC_BR;
                    end
                    done    = 1'b1;
                    state_n = ST_FETCH;
                end else if (is_lw || is_sw) begin
                    state_n = ST_MEM;
                end else begin
                    state_n = ST_WB;
                end
            end
            (state == ST_MEM): begin
                iord = 1'b1;
                aluc = ALUC_ADD;
                asb  = 1'b1;
                if (is_sw) begin
                    wrm = 1'b1;
                    if (ready) begin
                        done    = 1'b1;
                        state_n = ST_FETCH;
                    end
                end else begin
                    rdm = 1'b1;
                    if (ready) state_n = ST_WB;
                end
            end
            (state == ST_WB): begin
                aluc    = aluc_of(op_q);
                asb     = is_imm;
                wrg     = 1'b1;
                m2r     = is_lw;
                rdes    = op_q < OP_JMP;
                wfl     = op_q inside {OP_ADD, OP_SUB, OP_SUBC,
                                       OP_ADDC, OP_ADDI};
                done    = 1'b1;
                state_n = ST_FETCH;
            end
            default: state_n = ST_FETCH;
        endcase
    end

    // Gate with rst_n so a reset mid-instruction kills writes at once
    assign bus.PCWRITE    = rst_n & pcw;
    assign bus.IRWRITE    = rst_n & irw;
    assign bus.READMEM    = rst_n & rdm;
    assign bus.IORD       = rst_n & iord;
    assign bus.WRITEMEM   = rst_n & wrm;
    assign bus.ALUSRCB    = rst_n & asb;
    assign bus.WRITEREG   = rst_n & wrg;
    assign bus.MEMTOREG   = rst_n & m2r;
    assign bus.REGDES     = rst_n & rdes;
    assign bus.WRFLAG     = rst_n & wfl;
    assign bus.INSTR_DONE = rst_n & done;
    assign bus.PCSRC      = rst_n ? pcsrc : PCSRC_INC;
    assign bus.ALUC       = rst_n ? ALUCW'(aluc) : ALUCW'(ALUC_NOP);
    assign bus.STATE      = rst_n ? state : ST_FETCH;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected output vectors go
// through a scoreboard queue and are checked once per cycle.
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;

    multicycle_ctrl_if #(.OPW(4), .ALUCW(3)) bus ();

    multicycle_ctrl #(.OPW(4), .ALUCW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [10:0] PCW  = 11'h400;
    localparam logic [10:0] IRW  = 11'h200;
    localparam logic [10:0] RDM  = 11'h100;
    localparam logic [10:0] IOR  = 11'h080;
    localparam logic [10:0] WRM  = 11'h040;
    localparam logic [10:0] ASB  = 11'h020;
    localparam logic [10:0] WRG  = 11'h010;
    localparam logic [10:0] M2R  = 11'h008;
    localparam logic [10:0] RDS  = 11'h004;
    localparam logic [10:0] WFL  = 11'h002;
    localparam logic [10:0] DONE = 11'h001;

    int checks = 0;
    int errors = 0;
    logic [18:0] sb[$];

    function automatic logic [18:0] ev(input logic [2:0] st,
                                       input logic [1:0] ps,
                                       input logic [2:0] al,
                                       input logic [10:0] s);
        return {st, ps, al, s};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.STATE, bus.PCSRC, bus.ALUC,
                bus.PCWRITE, bus.IRWRITE, bus.READMEM, bus.IORD,
                bus.WRITEMEM, bus.ALUSRCB, bus.WRITEREG, bus.MEMTOREG,
                bus.REGDES, bus.WRFLAG, bus.INSTR_DONE};
    endfunction

    task automatic step(input string tag, input logic [18:0] e);
        logic [18:0] got;
        logic [18:0] x;
        sb.push_back(e);
        @(negedge clk);
        got = obs();
        x = sb.pop_front();
        checks++;
        assert (got === x) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        step(tag, ev(ST_FETCH, 2'b00, 3'b111, PCW | IRW | RDM));
    endtask

    task automatic decode(input string tag);
        step(tag, ev(ST_DECODE, 2'b00, 3'b111, 11'h0));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.run       = 1'b0;
        bus.op        = 4'h0;
        bus.ZERO      = 1'b0;
        bus.mem_ready = 1'b1;

        step("reset", ev(0, 2'b00, 3'b111, 11'h0));
        rst_n   = 1'b1;
        bus.run = 1'b1;

        // ADD; op changes after DECODE must be ignored
        bus.op = OP_ADD;
        fetch("add_f");
        decode("add_d");
        bus.op = OP_JMP;
        step("add_e", ev(ST_EXEC, 2'b00, 3'b101, 11'h0));
        step("add_w", ev(ST_WB, 2'b00, 3'b101, WRG | RDS | WFL | DONE));

        bus.op = OP_LW;
        fetch("lw_f");
        decode("lw_d");
        step("lw_e", ev(ST_EXEC, 2'b00, 3'b101, ASB));
        step("lw_m", ev(ST_MEM, 2'b00, 3'b101, ASB | IOR | RDM));
        step("lw_w", ev(ST_WB, 2'b00, 3'b101, ASB | WRG | M2R | DONE));

        bus.op = OP_SW;
        fetch("sw_f");
        decode("sw_d");
        step("sw_e", ev(ST_EXEC, 2'b00, 3'b101, ASB));
        step("sw_m", ev(ST_MEM, 2'b00, 3'b101, ASB | IOR | WRM | DONE));

        bus.op = OP_BEQ;
        bus.ZERO = 1'b1;
        fetch("beq1_f");
        decode("beq1_d");
        step("beq1_e", ev(ST_EXEC, 2'b01, 3'b001, PCW | DONE));
        bus.ZERO = 1'b0;
        fetch("beq0_f");
        decode("beq0_d");
        step("beq0_e", ev(ST_EXEC, 2'b00, 3'b001, DONE));

        bus.op = OP_BNE;
        bus.ZERO = 1'b1;
        fetch("bne1_f");
        decode("bne1_d");
        step("bne1_e", ev(ST_EXEC, 2'b00, 3'b001, DONE));
        bus.ZERO = 1'b0;
        fetch("bne0_f");
        decode("bne0_d");
        step("bne0_e", ev(ST_EXEC, 2'b01, 3'b001, PCW | DONE));

        bus.op = OP_JMPB;
        bus.ZERO = 1'b1;
        fetch("jmpb_f");
        decode("jmpb_d");
        step("jmpb_e", ev(ST_EXEC, 2'b01, 3'b011, PCW | DONE));
        bus.ZERO = 1'b0;

        bus.op = OP_JMP;
        fetch("jmp_f");
        step("jmp_d", ev(ST_DECODE, 2'b10, 3'b111, PCW | DONE));

        bus.op = OP_ORI;
        fetch("ori_f");
        decode("ori_d");
        step("ori_e", ev(ST_EXEC, 2'b00, 3'b110, ASB));
        step("ori_w", ev(ST_WB, 2'b00, 3'b110, ASB | WRG | DONE));

        // run drops mid-instruction: SLT still completes, then idle
        bus.op = OP_SLT;
        fetch("slt_f");
        bus.run = 1'b0;
        decode("slt_d");
        step("slt_e", ev(ST_EXEC, 2'b00, 3'b011, 11'h0));
        step("slt_w", ev(ST_WB, 2'b00, 3'b011, WRG | RDS | DONE));
        step("idle0", ev(ST_FETCH, 2'b00, 3'b111, 11'h0));
        step("idle1", ev(ST_FETCH, 2'b00, 3'b111, 11'h0));

        // reset while in EXEC
        bus.run = 1'b1;
        bus.op  = OP_ADD;
        fetch("rx_f");
        decode("rx_d");
        rst_n = 1'b0;
        step("rx_rst", ev(ST_FETCH, 2'b00, 3'b111, 11'h0));
        rst_n = 1'b1;
        bus.op = OP_SUB;
        fetch("sub_f");
        decode("sub_d");
        step("sub_e", ev(ST_EXEC, 2'b00, 3'b001, 11'h0));
        step("sub_w", ev(ST_WB, 2'b00, 3'b001, WRG | RDS | WFL | DONE));

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        bus.op = OP_SW;
        fetch("wsw_f");
        decode("wsw_d");
        step("wsw_e", ev(ST_EXEC, 2'b00, 3'b101, ASB));
        bus.mem_ready = 1'b0;
        step("wsw_m0", ev(ST_MEM, 2'b00, 3'b101, ASB | IOR | WRM));
        step("wsw_m1", ev(ST_MEM, 2'b00, 3'b101, ASB | IOR | WRM));
        step("wsw_m2", ev(ST_MEM, 2'b00, 3'b101, ASB | IOR | WRM));
        bus.mem_ready = 1'b1;
        step("wsw_m3", ev(ST_MEM, 2'b00, 3'b101, ASB | IOR | WRM | DONE));
        bus.mem_ready = 1'b0;
        step("wf_wait", ev(ST_FETCH, 2'b00, 3'b111, RDM));
        bus.mem_ready = 1'b1;
        fetch("wf_go");
        decode("wf_d");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 4-bit-opcode CPU datapath, sharing one ALU and one unified memory port across instruction phases.
- States: FETCH, DECODE, EXEC, MEM, WB. Per-state control strobes go to PC, IR, register file, ALU, memory and flag register.
- Replaces per-instruction single-cycle decode. Opcode map and ALUC encodings are unchanged.

Parameters:
- OPW, 4, opcode width.
- ALUCW, 3, ALU control width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  allow new instruction fetch
- op  in  OPW  opcode from IR (valid from DECODE)
- ZERO  in  1  ALU zero flag (combinational, this cycle)
- mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN)
- PCWRITE  out  1  load PC
- PCSRC  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- IRWRITE  out  1  load IR
- READMEM  out  1  memory read
- IORD  out  1  0 = address from PC, 1 = address from ALU
- WRITEMEM  out  1  memory write
- ALUC  out  ALUCW  ALU operation
- ALUSRCB  out  1  1 = immediate operand
- WRITEREG  out  1  register file write
- MEMTOREG  out  1  writeback from memory data
- REGDES  out  1  1 = rd destination (R-type)
- WRFLAG  out  1  update flag register
- INSTR_DONE  out  1  one-cycle pulse on instruction retire
- STATE  out  3  current state (debug)

Behaviour:
- Opcodes: AND 0, OR 1, ADD 2, SUB 3, SLT 4, SUBC 5, ADDC 6, JMP 7, ANDI 8, ORI 9, ADDI A, LW B, SW C, BEQ D, BNE E, JMPB F.
- ALUC: AND/ANDI 000; SUB/BEQ/BNE 001; SUBC 010; SLT/JMPB 011; ADDC 100; ADD/ADDI/LW/SW 101; OR/ORI 110; other 111.
- Reset (async, rst_n low):
  - State = FETCH, op_q = 0.
  - All strobes 0, PCSRC = 00, ALUC = 111, INSTR_DONE = 0.
  - Outputs are forced low combinationally while rst_n = 0, including reset mid-instruction. No partial write may complete.
- FETCH:
  - run = 0: stay in FETCH, all strobes 0 (idle).
  - run = 1: READMEM = 1, IORD = 0, IRWRITE = 1, PCWRITE = 1, PCSRC = 00, then go to DECODE.
- DECODE:
  - op_q <= op. Later states decode op_q only; changes on op after DECODE are ignored.
  - op == JMP: PCWRITE = 1, PCSRC = 10, INSTR_DONE = 1, then FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - ALUC from op_q. ALUSRCB = 1 for ANDI/ORI/ADDI/LW/SW.
  - BEQ, BNE, JMPB:
    - Take branch when (BEQ & ZERO) | (BNE & ~ZERO) | (JMPB & ZERO).
    - Taken: PCWRITE = 1, PCSRC = 01. ZERO is sampled combinationally (Mealy).
    - INSTR_DONE = 1, then FETCH, taken or not.
  - LW, SW: go to MEM.
  - All others: go to WB.
- MEM:
  - IORD = 1, ALUC = 101, ALUSRCB = 1 (address held).
  - SW: WRITEMEM = 1, INSTR_DONE = 1, then FETCH.
  - LW: READMEM = 1, then WB.
- WB:
  - WRITEREG = 1.
  - MEMTOREG = 1 only for LW.
  - REGDES = 1 for opcodes 0–6.
  - WRFLAG = 1 for ADD/SUB/SUBC/ADDC/ADDI.
  - ALUC and ALUSRCB held from EXEC.
  - INSTR_DONE = 1, then FETCH.
- CPI:
  - JMP 2; branches 3; SW 4; ALU ops 4; LW 5.
  - Add wait cycles when MEM_WAIT_EN is defined.
- WRITEREG, WRITEMEM and PCWRITE never assert in the same cycle, except PCWRITE with IRWRITE in FETCH.
- run deasserting mid-instruction: the current instruction completes; the block then idles in FETCH.
- STATE encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4. Codes 5–7 are illegal and go to FETCH on the next clock with strobes 0.

Optional Feature:
- MULTICYCLE_CTRL_MEM_WAIT_EN.
- Defined: FETCH and MEM hold state and keep their strobes asserted while mem_ready = 0. PCWRITE and IRWRITE (FETCH), WRITEMEM and INSTR_DONE (SW), and the LW advance to WB take effect only in the cycle where mem_ready = 1.
- Undefined: mem_ready is ignored; every memory access takes one cycle.

Decomposition:
- Shared package `cpu_pkg` holds:
  - opcode localparams (AND..JMPB);
  - ALUC encodings;
  - state encodings;
  - PCSRC encodings.
- Existing ctrlunit-style combinational decode could be reused, but the FSM is kept as one module with no sub-module. Output decode lives in one always_comb from {state, op_q, ZERO}.

Test Plan:
- Reset mid-EXEC: rst_n low while STATE = 2 -> all strobes 0 immediately; STATE = 0 after release; no WRITEREG pulse.
- ADD (op = 2), run = 1 -> STATE 0,1,2,4,0; ALUC = 101 in EXEC; WB has WRITEREG = 1, REGDES = 1, WRFLAG = 1; INSTR_DONE in WB.
- LW (op = B) -> 5 cycles; MEM has READMEM = 1, IORD = 1; WB has MEMTOREG = 1, REGDES = 0, WRFLAG = 0.
- BEQ (op = D) with ZERO = 1 -> EXEC has PCWRITE = 1, PCSRC = 01; with ZERO = 0 -> PCWRITE = 0. BNE gives the opposite. JMPB with ZERO = 1 -> ALUC = 011 and branch taken.
- JMP (op = 7) -> DECODE has PCWRITE = 1, PCSRC = 10, INSTR_DONE = 1; 2-cycle CPI. run = 0 -> FETCH idle with all strobes 0.
- With MULTICYCLE_CTRL_MEM_WAIT_EN, SW with mem_ready low for 3 cycles -> WRITEMEM held for 4 cycles; INSTR_DONE only on the mem_ready = 1 cycle.
